// File: rtl/dmem_bank.sv
// -----------------------------------------------------------------------------
// dmem_bank -- parametrised RV32I data memory
//
// This block sits between the LSU/MEM stage and the on-chip RAM array. It
// takes one request per cycle with no backpressure once ready, and returns
// responses in order.
//
// Loads return the byte, half or word selected by addr[1:0], sign- or
// zero-extended. Stores write only the lanes they cover. Misaligned accesses,
// the reserved size code and out-of-range addresses are reported on rsp_err.
// An erroring store leaves the array unchanged, and an erroring access
// returns data 0. After reset, a sweep can zero the whole array before the
// first request is accepted.
//
// Parameters
//   DEPTH_WORDS    number of 32-bit words (power of 2, >= 4)
//   READ_LATENCY   cycles from accept to rsp_valid (1..3)
//   CLEAR_ON_RESET 1: zero-clear sweep after reset, 0: ready immediately
//
// Ports
//   clk               in   clock, rising edge
//   reset_n           in   asynchronous active-low reset
//   data_mem_req      in   request valid
//   data_mem_wr       in   1 = store, 0 = load
//   data_mem_addr     in   byte address [31:0]
//   data_mem_wr_data  in   store data, right-aligned [31:0]
//   data_mem_byte_en  in   size: 00 byte, 01 half, 11 word, 10 reserved
//   data_mem_unsigned in   loads: 1 = zero-extend, 0 = sign-extend
//   req_ready         out  request accepted when data_mem_req && req_ready
//   rsp_valid         out  one-cycle pulse per accepted request
//   mem_rd_data       out  extended load result [31:0]; 0 for stores/errors
//   rsp_err           out  error flag, qualified by rsp_valid
//
// Optional build macro DMEM_ERR_STATUS_EN adds:
//   err_clr           in   one-cycle pulse clears err_sticky/err_addr
//   err_sticky        out  set by the first erroring request
//   err_addr          out  address of that first erroring request [31:0]
//
// FSM states
//   state    | meaning
//   ST_INIT  | zero-clear sweep in progress, requests not accepted
//   ST_READY | normal operation, req_ready=1 every cycle
// -----------------------------------------------------------------------------
module dmem_bank #(
  parameter int DEPTH_WORDS    = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_mem_req,
  input  logic        data_mem_wr,
  input  logic [31:0] data_mem_addr,
  input  logic [31:0] data_mem_wr_data,
  input  logic [1:0]  data_mem_byte_en,
  input  logic        data_mem_unsigned,
`ifdef DMEM_ERR_STATUS_EN
  input  logic        err_clr,
  output logic        err_sticky,
  output logic [31:0] err_addr,
`endif
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] mem_rd_data,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          ready_q, ready_d;
  logic          clr_we;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          oor;
  logic          mis;
  logic          req_err;
  logic          accept;
  logic          st_we;
  logic [3:0]    lane_we;
  logic [31:0]   wdata_al;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_data;

  logic [READ_LATENCY-1:0] pv_q;
  logic [READ_LATENCY-1:0] pe_q;
  logic [31:0]             pd_q [READ_LATENCY];

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_IDX) begin
          state_d   = ST_READY;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
    // req_ready is registered so that it reads 0 while reset is held, even
    // when the sweep is disabled.
    ready_d = (state_d == ST_READY);
  end

  assign req_ready = ready_q;
  assign accept    = data_mem_req & ready_q;

  // ---------------------------------------------------------------------------
  // Request decode and error checks
  // ---------------------------------------------------------------------------
  assign idx = data_mem_addr[AW+1:2];
  assign oor = |data_mem_addr[31:AW+2];

  always_comb begin
    mis = 1'b0;
    case (data_mem_byte_en)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = data_mem_addr[0];
      SZ_WORD: mis = |data_mem_addr[1:0];
      default: mis = 1'b1;
    endcase
  end

  assign req_err = oor | mis;
  assign st_we   = accept & data_mem_wr & ~req_err;

  // Store data is replicated across lanes, so the lane enables alone pick
  // which bytes land in the word.
  always_comb begin
    lane_we  = 4'b0000;
    wdata_al = data_mem_wr_data;
    case (data_mem_byte_en)
      SZ_BYTE: begin
        lane_we  = 4'b0001 << data_mem_addr[1:0];
        wdata_al = {4{data_mem_wr_data[7:0]}};
      end
      SZ_HALF: begin
        lane_we  = data_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{data_mem_wr_data[15:0]}};
      end
      SZ_WORD: begin
        lane_we  = 4'b1111;
        wdata_al = data_mem_wr_data;
      end
      default: begin
        lane_we  = 4'b0000;
        wdata_al = data_mem_wr_data;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM array: the sweep owns the write port while it runs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (st_we) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_we[l]) begin
          mem_q[idx][8*l +: 8] <= wdata_al[8*l +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load path: the word is read and extended in the accept cycle. A store
  // commits at its accept edge, so a load in the next cycle sees the new data.
  // ---------------------------------------------------------------------------
  assign rd_word = mem_q[idx];

  always_comb begin
    byte_sel = rd_word[7:0];
    case (data_mem_addr[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = data_mem_addr[1] ? rd_word[31:16] : rd_word[15:0];

    ld_data = '0;
    case (data_mem_byte_en)
      SZ_BYTE: ld_data = {{24{~data_mem_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_data = {{16{~data_mem_unsigned & half_sel[15]}}, half_sel};
      SZ_WORD: ld_data = rd_word;
      default: ld_data = '0;
    endcase
    if (data_mem_wr || req_err) begin
      ld_data = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline, READ_LATENCY stages deep. Valid bits shift every cycle.
  // Data and error move only with a valid entry, so the last stage (and
  // mem_rd_data) holds its value while bubbles pass through.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= accept;
      if (accept) begin
        pd_q[0] <= ld_data;
        pe_q[0] <= req_err;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) begin
          pd_q[i] <= pd_q[i-1];
          pe_q[i] <= pe_q[i-1];
        end
      end
    end
  end

  assign rsp_valid   = pv_q[READ_LATENCY-1];
  assign rsp_err     = pv_q[READ_LATENCY-1] & pe_q[READ_LATENCY-1];
  assign mem_rd_data = pd_q[READ_LATENCY-1];

`ifdef DMEM_ERR_STATUS_EN
  // ---------------------------------------------------------------------------
  // Sticky error capture. When a clear and a new error arrive in the same
  // cycle, the clear takes effect first. The new error is parked in pend_q
  // and captured on the following cycle.
  // ---------------------------------------------------------------------------
  logic        err_sticky_q;
  logic [31:0] err_addr_q;
  logic        pend_q;
  logic [31:0] pend_addr_q;
  logic        new_err;

  assign new_err = accept & req_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
    end else if (err_clr) begin
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
      if (new_err) begin
        pend_q      <= 1'b1;
        pend_addr_q <= data_mem_addr;
      end
    end else if (pend_q) begin
      err_sticky_q <= 1'b1;
      err_addr_q   <= pend_addr_q;
      pend_q       <= 1'b0;
    end else if (new_err && !err_sticky_q) begin
      err_sticky_q <= 1'b1;
      err_addr_q   <= data_mem_addr;
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_addr   = err_addr_q;
`endif

endmodule

// File: tb/tb_dmem_bank.sv
// -----------------------------------------------------------------------------
// tb_dmem_bank -- scoreboard testbench for dmem_bank
//   u_dut_a : 16 words,   READ_LATENCY 1, clear on reset
//   u_dut_b : 1024 words, READ_LATENCY 3, clear on reset
// Drivers push expected {data, err, cycle} entries. Negedge monitors pop them
// and compare when rsp_valid is seen.
// -----------------------------------------------------------------------------
module tb_dmem_bank;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t xa;
  exp_t xb;

  logic        a_rst_n, a_req, a_wr, a_uns;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_be;
  logic        a_ready, a_rsp_valid, a_err;
  logic [31:0] a_rd;

  logic        b_rst_n, b_req, b_wr, b_uns;
  logic [31:0] b_addr, b_wdata;
  logic [1:0]  b_be;
  logic        b_ready, b_rsp_valid, b_err;
  logic [31:0] b_rd;

`ifdef DMEM_ERR_STATUS_EN
  logic        a_err_clr, a_err_sticky, b_err_clr, b_err_sticky;
  logic [31:0] a_err_addr, b_err_addr;
`endif

  dmem_bank #(.DEPTH_WORDS(16), .READ_LATENCY(LAT_A), .CLEAR_ON_RESET(1)) u_dut_a (
    .clk               (clk),
    .reset_n           (a_rst_n),
    .data_mem_req      (a_req),
    .data_mem_wr       (a_wr),
    .data_mem_addr     (a_addr),
    .data_mem_wr_data  (a_wdata),
    .data_mem_byte_en  (a_be),
    .data_mem_unsigned (a_uns),
`ifdef DMEM_ERR_STATUS_EN
    .err_clr           (a_err_clr),
    .err_sticky        (a_err_sticky),
    .err_addr          (a_err_addr),
`endif
    .req_ready         (a_ready),
    .rsp_valid         (a_rsp_valid),
    .mem_rd_data       (a_rd),
    .rsp_err           (a_err)
  );

  dmem_bank #(.DEPTH_WORDS(1024), .READ_LATENCY(LAT_B), .CLEAR_ON_RESET(1)) u_dut_b (
    .clk               (clk),
    .reset_n           (b_rst_n),
    .data_mem_req      (b_req),
    .data_mem_wr       (b_wr),
    .data_mem_addr     (b_addr),
    .data_mem_wr_data  (b_wdata),
    .data_mem_byte_en  (b_be),
    .data_mem_unsigned (b_uns),
`ifdef DMEM_ERR_STATUS_EN
    .err_clr           (b_err_clr),
    .err_sticky        (b_err_sticky),
    .err_addr          (b_err_addr),
`endif
    .req_ready         (b_ready),
    .rsp_valid         (b_rsp_valid),
    .mem_rd_data       (b_rd),
    .rsp_err           (b_err)
  );

  // Response monitors
  always @(negedge clk) begin
    if (a_rsp_valid === 1'b1) begin
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_rsp cyc=%0d data=%h err=%b", cyc, a_rd, a_err);
      end else begin
        xa = qa.pop_front();
        tests++;
        if (a_rd !== xa.d) begin
          fails++; $display("FAIL a_rsp_data got=%h exp=%h", a_rd, xa.d);
        end
        tests++;
        if (a_err !== xa.e) begin
          fails++; $display("FAIL a_rsp_err got=%b exp=%b", a_err, xa.e);
        end
        tests++;
        if (cyc != xa.c) begin
          fails++; $display("FAIL a_rsp_cycle got=%0d exp=%0d", cyc, xa.c);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_rsp_valid === 1'b1) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_rsp cyc=%0d data=%h err=%b", cyc, b_rd, b_err);
      end else begin
        xb = qb.pop_front();
        tests++;
        if (b_rd !== xb.d) begin
          fails++; $display("FAIL b_rsp_data got=%h exp=%h", b_rd, xb.d);
        end
        tests++;
        if (b_err !== xb.e) begin
          fails++; $display("FAIL b_rsp_err got=%b exp=%b", b_err, xb.e);
        end
        tests++;
        if (cyc != xb.c) begin
          fails++; $display("FAIL b_rsp_cycle got=%0d exp=%0d", cyc, xb.c);
        end
      end
    end
  end

  // Drivers: present a request for one accept edge and push its expectation.
  task automatic drive_a(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] be, input logic uns,
                         input logic [31:0] ed, input logic ee);
    @(negedge clk);
    a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wd; a_be = be; a_uns = uns;
    qa.push_back('{d: ed, e: ee, c: cyc + LAT_A});
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic drive_b(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] be, input logic uns,
                         input logic [31:0] ed, input logic ee);
    @(negedge clk);
    b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wd; b_be = be; b_uns = uns;
    qb.push_back('{d: ed, e: ee, c: cyc + LAT_B});
    @(posedge clk); #1;
    b_req = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (qa.size() != 0) begin
      fails++; $display("FAIL a_drain pending=%0d", qa.size()); qa.delete();
    end
  endtask

  task automatic drain_b();
    int n = 0;
    while (qb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (qb.size() != 0) begin
      fails++; $display("FAIL b_drain pending=%0d", qb.size()); qb.delete();
    end
  endtask

  // Called at the negedge where reset is released; counts low-ready cycles.
  task automatic a_wait_ready(output int cnt);
    cnt = 0;
    while (a_ready !== 1'b1 && cnt < 2000) begin cnt++; @(negedge clk); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got=%b exp=0", a_ready); end
    tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got=%b exp=0", a_rsp_valid); end
    tests++; if (a_rd !== 32'h0) begin fails++; $display("FAIL rst_rd_data got=%h exp=0", a_rd); end
    tests++; if (a_err !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", a_err); end
    tests++; if (b_ready !== 1'b0) begin fails++; $display("FAIL rst_b_ready got=%b exp=0", b_ready); end
`ifdef DMEM_ERR_STATUS_EN
    tests++; if (a_err_sticky !== 1'b0) begin fails++; $display("FAIL rst_err_sticky got=%b exp=0", a_err_sticky); end
    tests++; if (a_err_addr !== 32'h0) begin fails++; $display("FAIL rst_err_addr got=%h exp=0", a_err_addr); end
`endif
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    begin
      int cnt;
      a_wait_ready(cnt);
      tests++;
      if (cnt != 16) begin fails++; $display("FAIL init_low_cycles got=%0d exp=16", cnt); end
    end
    drive_a(1'b0, 32'h3C, 32'h0, 2'b11, 1'b0, 32'h0, 1'b0);
    drain_a();
  endtask

  task automatic test_reset_clear();
    int cnt;
    drive_a(1'b1, 32'h3C, 32'hA5A5A5A5, 2'b11, 1'b0, 32'h0, 1'b0);
    drive_a(1'b1, 32'h00, 32'h5A5A5A5A, 2'b11, 1'b0, 32'h0, 1'b0);
    drive_a(1'b0, 32'h3C, 32'h0, 2'b11, 1'b0, 32'hA5A5A5A5, 1'b0);
    drain_a();
    @(negedge clk); a_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL midsweep_ready got=%b exp=0", a_ready); end
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    a_wait_ready(cnt);
    tests++;
    if (cnt != 16) begin fails++; $display("FAIL sweep_restart_cycles got=%0d exp=16", cnt); end
    drive_a(1'b0, 32'h3C, 32'h0, 2'b11, 1'b0, 32'h0, 1'b0);
    drive_a(1'b0, 32'h00, 32'h0, 2'b11, 1'b0, 32'h0, 1'b0);
    drain_a();
  endtask

  task automatic test_store_merge();
    drive_a(1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 32'h0, 1'b0);
    drive_a(1'b1, 32'h12, 32'hAAAAAA7F, 2'b00, 1'b0, 32'h0, 1'b0);
    drive_a(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDE7FBEEF, 1'b0);
    drive_a(1'b1, 32'h16, 32'h55551234, 2'b01, 1'b0, 32'h0, 1'b0);
    drive_a(1'b0, 32'h14, 32'h0, 2'b11, 1'b0, 32'h12340000, 1'b0);
    drive_a(1'b1, 32'h18, 32'h00000011, 2'b00, 1'b0, 32'h0, 1'b0);
    drive_a(1'b1, 32'h19, 32'h00000022, 2'b00, 1'b0, 32'h0, 1'b0);
    drive_a(1'b0, 32'h18, 32'h0, 2'b11, 1'b0, 32'h00002211, 1'b0);
    drain_a();
  endtask

  task automatic test_load_extend();
    drive_a(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'hFFFFFFDE, 1'b0);
    drive_a(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'h000000DE, 1'b0);
    drive_a(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 32'hFFFFDE7F, 1'b0);
    drive_a(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 32'h0000DE7F, 1'b0);
    drive_a(1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 32'h0000BEEF, 1'b0);
    drive_a(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 32'hFFFFFFEF, 1'b0);
    drive_a(1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 32'h000000BE, 1'b0);
    drive_a(1'b0, 32'h18, 32'h0, 2'b00, 1'b0, 32'h00000011, 1'b0);
    drive_a(1'b0, 32'h10, 32'h0, 2'b11, 1'b1, 32'hDE7FBEEF, 1'b0);
    drain_a();
  endtask

  task automatic test_errors();
    drive_a(1'b1, 32'h11, 32'h0000FFFF, 2'b01, 1'b0, 32'h0, 1'b1);
    drive_a(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDE7FBEEF, 1'b0);
    drive_a(1'b1, 32'h12, 32'h00000000, 2'b11, 1'b0, 32'h0, 1'b1);
    drive_a(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDE7FBEEF, 1'b0);
    drive_a(1'b0, 32'h11, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    drive_a(1'b0, 32'h13, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1);
    drive_a(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    drive_a(1'b1, 32'h40, 32'h12345678, 2'b11, 1'b0, 32'h0, 1'b1);
    drive_a(1'b0, 32'h00, 32'h0, 2'b11, 1'b0, 32'h0, 1'b0);
    drive_a(1'b0, 32'h80000010, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    drive_a(1'b0, 32'h3C, 32'h0, 2'b11, 1'b0, 32'h0, 1'b0);
    drive_a(1'b0, 32'h43, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1);
    drain_a();
  endtask

  task automatic test_back_to_back();
    drive_a(1'b1, 32'h20, 32'hCAFEF00D, 2'b11, 1'b0, 32'h0, 1'b0);
    drive_a(1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 32'hCAFEF00D, 1'b0);
    drive_a(1'b1, 32'h21, 32'h00000099, 2'b00, 1'b0, 32'h0, 1'b0);
    drive_a(1'b0, 32'h20, 32'h0, 2'b01, 1'b1, 32'h0000990D, 1'b0);
    drive_a(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 32'hFFFFFF99, 1'b0);
    tests++;
    if (a_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got=%b exp=1", a_ready); end
    drain_a();
  endtask

`ifdef DMEM_ERR_STATUS_EN
  task automatic test_err_status();
    tests++; if (a_err_sticky !== 1'b1) begin fails++; $display("FAIL es_first_sticky got=%b exp=1", a_err_sticky); end
    tests++; if (a_err_addr !== 32'h11) begin fails++; $display("FAIL es_first_addr got=%h exp=00000011", a_err_addr); end
    @(negedge clk); a_err_clr = 1'b1;
    @(posedge clk); #1; a_err_clr = 1'b0;
    @(negedge clk);
    tests++; if (a_err_sticky !== 1'b0) begin fails++; $display("FAIL es_clr_sticky got=%b exp=0", a_err_sticky); end
    drive_a(1'b0, 32'h21, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1);
    drive_a(1'b0, 32'h42, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    drain_a();
    tests++; if (a_err_sticky !== 1'b1) begin fails++; $display("FAIL es_sticky got=%b exp=1", a_err_sticky); end
    tests++; if (a_err_addr !== 32'h21) begin fails++; $display("FAIL es_addr got=%h exp=00000021", a_err_addr); end
    @(negedge clk); a_err_clr = 1'b1;
    @(posedge clk); #1; a_err_clr = 1'b0;
    @(negedge clk);
    tests++; if (a_err_sticky !== 1'b0) begin fails++; $display("FAIL es_clr2_sticky got=%b exp=0", a_err_sticky); end
    tests++; if (a_err_addr !== 32'h0) begin fails++; $display("FAIL es_clr2_addr got=%h exp=0", a_err_addr); end
    @(negedge clk);
    a_err_clr = 1'b1;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 32'h31; a_wdata = 32'h0; a_be = 2'b01; a_uns = 1'b0;
    qa.push_back('{d: 32'h0, e: 1'b1, c: cyc + LAT_A});
    @(posedge clk); #1;
    a_err_clr = 1'b0; a_req = 1'b0;
    @(negedge clk);
    tests++; if (a_err_sticky !== 1'b0) begin fails++; $display("FAIL es_clr_wins got=%b exp=0", a_err_sticky); end
    @(negedge clk);
    tests++; if (a_err_sticky !== 1'b1) begin fails++; $display("FAIL es_late_sticky got=%b exp=1", a_err_sticky); end
    tests++; if (a_err_addr !== 32'h31) begin fails++; $display("FAIL es_late_addr got=%h exp=00000031", a_err_addr); end
    drain_a();
  endtask
`endif

  task automatic test_latency3();
    int n = 0;
    while (b_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    tests++;
    if (b_ready !== 1'b1) begin fails++; $display("FAIL b_ready_timeout got=%b exp=1", b_ready); end
    drive_b(1'b1, 32'h0, 32'h11111111, 2'b11, 1'b0, 32'h0, 1'b0);
    drive_b(1'b1, 32'h4, 32'h22222222, 2'b11, 1'b0, 32'h0, 1'b0);
    drive_b(1'b1, 32'h8, 32'h33333333, 2'b11, 1'b0, 32'h0, 1'b0);
    drive_b(1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h11111111, 1'b0);
    drive_b(1'b0, 32'h4, 32'h0, 2'b11, 1'b0, 32'h22222222, 1'b0);
    drive_b(1'b0, 32'h8, 32'h0, 2'b11, 1'b0, 32'h33333333, 1'b0);
    drive_b(1'b1, 32'hFFC, 32'h0BADF00D, 2'b11, 1'b0, 32'h0, 1'b0);
    drive_b(1'b0, 32'hFFC, 32'h0, 2'b11, 1'b0, 32'h0BADF00D, 1'b0);
    drive_b(1'b1, 32'h1000, 32'hBAD0BAD0, 2'b11, 1'b0, 32'h0, 1'b1);
    drive_b(1'b0, 32'h1000, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    drive_b(1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h11111111, 1'b0);
    drain_b();
  endtask

  task automatic test_reset_inflight();
    int cnt = 0;
    int seen = 0;
    drive_b(1'b0, 32'h4, 32'h0, 2'b11, 1'b0, 32'h22222222, 1'b0);
    b_rst_n = 1'b0;
    qb.delete();
    repeat (2) @(negedge clk);
    tests++; if (b_rsp_valid !== 1'b0) begin fails++; $display("FAIL inflight_rst_valid got=%b exp=0", b_rsp_valid); end
    tests++; if (b_rd !== 32'h0) begin fails++; $display("FAIL inflight_rst_data got=%h exp=0", b_rd); end
    b_rst_n = 1'b1;
    while (b_ready !== 1'b1 && cnt < 2000) begin
      if (b_rsp_valid === 1'b1) seen++;
      cnt++;
      @(negedge clk);
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL inflight_dropped got=%0d exp=0", seen); end
    tests++;
    if (cnt != 1024) begin fails++; $display("FAIL b_init_low_cycles got=%0d exp=1024", cnt); end
    drive_b(1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h0, 1'b0);
    drain_b();
  endtask

  initial begin
    a_rst_n = 1'b0; a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0; a_be = 2'b11; a_uns = 1'b0;
    b_rst_n = 1'b0; b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_be = 2'b11; b_uns = 1'b0;
`ifdef DMEM_ERR_STATUS_EN
    a_err_clr = 1'b0; b_err_clr = 1'b0;
`endif
    test_reset();
    test_reset_clear();
    test_store_merge();
    test_load_extend();
    test_errors();
    test_back_to_back();
`ifdef DMEM_ERR_STATUS_EN
    test_err_status();
`endif
    test_latency3();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
